// File: rtl/amp_array_pkg.sv
// Shared types, default parameters and helpers for the amp_array block.
package amp_array_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DW_DEF       = 16;
    localparam int GW_DEF       = 8;
    localparam int FRAC_DEF     = 4;
    localparam int LP_SHIFT_DEF = 3;

    // Unity gain for the default fractional format (1.0 = 1 << FRAC).
    localparam int GAIN_UNITY = 1 << FRAC_DEF;

    // Working width for the generic saturation helper.
    localparam int SAT_W = 64;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_LP     = 1'b1
    } lane_mode_t;

    // Clamp a signed value to the range of a signed dw-bit number.
    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] x,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/amp_lane.sv
// One amplifier lane: gain multiply with round-half-up (stage 1), optional
// first-order low-pass, saturation and sticky overflow flag (stage 2).
// Stage enables come from the parent's stall pipeline.
module amp_lane
    import amp_array_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int GW       = GW_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int LP_SHIFT = LP_SHIFT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld1,
    input  logic          i_ld2,
    input  logic [DW-1:0] i_in,
    input  logic [GW-1:0] i_gain,
    input  logic          i_mode,
    input  logic          i_mode_clr,
    input  logic          i_flag_clr,
    output logic [DW-1:0] o_y,
    output logic          o_sat
);

    localparam int PW = DW + GW;
    localparam logic signed [PW-1:0] ROUND = PW'(1 << (FRAC - 1));

    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_p;
    logic signed [PW:0]      w_diff;
    logic signed [PW-1:0]    w_s_next;
    logic signed [PW-1:0]    w_pre;
    logic signed [SAT_W-1:0] w_clamped;
    logic                    w_clip;
    logic                    w_lp;

    logic signed [PW-1:0]    r_p;
    logic signed [PW-1:0]    r_s;
    logic [DW-1:0]           r_y;
    logic                    r_sat;

    // Datapath: scaled product for stage 1, filter update and clamp for stage 2.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch is inferred.
        w_prod    = PW'($signed(i_in)) * PW'($signed(i_gain));
        w_p       = (w_prod + ROUND) >>> FRAC;
        w_diff    = (PW+1)'(r_p) - (PW+1)'(r_s);
        w_s_next  = PW'((PW+1)'(r_s) + (w_diff >>> LP_SHIFT));
        w_lp      = (lane_mode_t'(i_mode) == MODE_LP);
        w_pre     = w_lp ? w_s_next : r_p;
        w_clamped = sat_dw(SAT_W'(w_pre), DW);
        w_clip    = (w_clamped != SAT_W'(w_pre));
    end

    // Stage registers, filter state and sticky flag (set beats clear).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_p   <= '0;
            r_s   <= '0;
            r_y   <= '0;
            r_sat <= 1'b0;
        end else begin
            if (i_ld1) begin
                r_p <= w_p;
            end
            if (i_ld2) begin
                r_y <= w_clamped[DW-1:0];
            end
            if (i_mode_clr) begin
                r_s <= '0;
            end else if (i_ld2 && w_lp) begin
                r_s <= w_s_next;
            end
            r_sat <= (r_sat & ~i_flag_clr) | (i_ld2 & w_clip);
        end
    end

    assign o_y   = r_y;
    assign o_sat = r_sat;

endmodule

// File: rtl/amp_array.sv
// Multi-channel amplifier: valid/ready two-stage stall pipeline, per-lane
// gain/mode register file and a generate loop of amp_lane instances.
module amp_array
    import amp_array_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DW       = DW_DEF,
    parameter int GW       = GW_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int LP_SHIFT = LP_SHIFT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*DW-1:0]      in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*DW-1:0]      out_data,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic [GW-1:0]               cfg_gain,
    input  logic                        cfg_lp,
    input  logic                        cfg_clr,
    output logic [CHANNELS-1:0]         sat_flag
);

    localparam int CHW = $clog2(CHANNELS);
    localparam logic [GW-1:0] UNITY = GW'((FRAC == FRAC_DEF) ? GAIN_UNITY : (1 << FRAC));

    logic                r_v1;
    logic                r_v2;
    logic                w_adv1;
    logic                w_adv2;
    logic                w_ld1;
    logic                w_ld2;
    logic [CHANNELS-1:0] w_we;
    logic [CHANNELS-1:0] w_mode_clr;

    logic [GW-1:0]       r_gain [CHANNELS];
    lane_mode_t          r_mode [CHANNELS];

    // Handshake: a stage advances when it is empty or the stage after it advances.
    always_comb begin
        w_adv2    = !r_v2 || out_ready;
        w_adv1    = !r_v1 || w_adv2;
        w_ld1     = in_valid && w_adv1;
        w_ld2     = r_v1 && w_adv2;
        in_ready  = w_adv1;
        out_valid = r_v2;
    end

    // Config write decode; lane indices that do not exist never match.
    always_comb begin
        w_we       = '0;
        w_mode_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_we[i]       = cfg_we && (cfg_ch == CHW'(i));
            w_mode_clr[i] = cfg_we && (cfg_ch == CHW'(i)) &&
                            (lane_mode_t'(cfg_lp) != r_mode[i]);
        end
    end

    // Pipeline valid bits; a reset discards whatever is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
            end
        end
    end

    // Per-lane gain and mode register file.
    always_ff @(posedge clk) begin
        // NOTE: this register file is reset explicitly so lanes start at unity gain, bypass.
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_gain[i] <= UNITY;
                r_mode[i] <= MODE_BYPASS;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_we[i]) begin
                    r_gain[i] <= cfg_gain;
                    r_mode[i] <= lane_mode_t'(cfg_lp);
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        amp_lane #(
            .DW       (DW),
            .GW       (GW),
            .FRAC     (FRAC),
            .LP_SHIFT (LP_SHIFT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_ld1      (w_ld1),
            .i_ld2      (w_ld2),
            .i_in       (in_data[g*DW +: DW]),
            .i_gain     (r_gain[g]),
            .i_mode     (r_mode[g]),
            .i_mode_clr (w_mode_clr[g]),
            .i_flag_clr (cfg_clr),
            .o_y        (out_data[g*DW +: DW]),
            .o_sat      (sat_flag[g])
        );
    end

endmodule
